// File: rtl/sram_client_pkg.sv
// Shared types for the SRAM client side: request-master states and the default
// grant/completion timeout.
package sram_client_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    typedef enum logic [3:0] {
        IDLE,
        WR_FETCH,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_HOLD,
        FINISH,
        ABORT
    } state_t;

    // States in which the master waits on the controller and is timed.
    function automatic logic is_wait_state(input state_t s);
        return (s == WR_REQ) || (s == WR_WAIT) || (s == RD_REQ) || (s == RD_WAIT);
    endfunction

endpackage

// File: rtl/sram_watchdog.sv
// Cycle counter that flags when a wait on the SRAM controller has lasted
// TIMEOUT_CYCLES cycles; cleared on every entry into a waiting state.
module sram_watchdog
    import sram_client_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] count;

    // Saturates at the terminal value so a held enable never wraps back to 0.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sram_request_master.sv
// Host-side burst master: turns a host read/write burst command into one
// request/grant/completion handshake per byte towards the SRAM controller.
module sram_request_master
    import sram_client_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iCmdValid,
    output logic                  oCmdReady,
    input  logic                  iCmdWrite,
    input  logic [3:0]            iCmdCount,
    input  logic [DATA_WIDTH-1:0] iWrData,
    input  logic                  iWrValid,
    output logic                  oWrReady,
    output logic [DATA_WIDTH-1:0] oRdData,
    output logic                  oRdValid,
    input  logic                  iRdReady,
    output logic                  oDone,
    output logic                  oError,
    output logic                  oBusy,
    output logic                  oReadRequest,
    output logic                  oWriteRequest,
    output logic [DATA_WIDTH-1:0] oData,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iReadGranted,
    input  logic                  iWriteGranted,
    input  logic                  iReadDataValid,
    input  logic                  iDataWritten,
    output state_t                oState
);

    // Host handshakes are valid/ready: a beat moves on the rising edge where both
    // are high; the controller side uses single-cycle grant/data pulses instead.

    state_t     state;
    state_t     next_state;
    logic [3:0] remaining;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;

    sram_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (iClk),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    assign wd_enable = is_wait_state(state);
    assign wd_clear  = iReset || (is_wait_state(next_state) && (next_state != state));

    // A real grant/data event in the expiry cycle wins over the timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (iCmdValid) next_state = iCmdWrite ? WR_FETCH : RD_REQ;
            WR_FETCH: if (iWrValid) next_state = WR_REQ;
            WR_REQ: begin
                if (iWriteGranted)   next_state = WR_WAIT;
                else if (wd_expired) next_state = ABORT;
            end
            WR_WAIT: begin
                if (iDataWritten)    next_state = (remaining == 4'd0) ? FINISH : WR_FETCH;
                else if (wd_expired) next_state = ABORT;
            end
            RD_REQ: begin
                if (iReadGranted)    next_state = RD_WAIT;
                else if (wd_expired) next_state = ABORT;
            end
            RD_WAIT: begin
                if (iReadDataValid)  next_state = RD_HOLD;
                else if (wd_expired) next_state = ABORT;
            end
            RD_HOLD:  if (iRdReady) next_state = (remaining == 4'd0) ? FINISH : RD_REQ;
            FINISH:   next_state = IDLE;
            ABORT:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= IDLE;
            remaining <= 4'd0;
            oData     <= '0;
            oRdData   <= '0;
            oRdValid  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && iCmdValid) begin
                remaining <= iCmdCount;
            end else if (next_state == ABORT) begin
                remaining <= 4'd0;
            end else if ((state == WR_WAIT && next_state == WR_FETCH) ||
                         (state == RD_HOLD && next_state == RD_REQ)) begin
                remaining <= remaining - 4'd1;
            end
            if (state == WR_FETCH && iWrValid) begin
                oData <= iWrData;
            end
            if (state == RD_WAIT && next_state == RD_HOLD) begin
                oRdData  <= iData;
                oRdValid <= 1'b1;
            end else if ((state == RD_HOLD && iRdReady) || next_state == ABORT) begin
                oRdValid <= 1'b0;
            end
        end
    end

    assign oCmdReady     = (state == IDLE);
    assign oBusy         = (state != IDLE);
    assign oWrReady      = (state == WR_FETCH);
    assign oWriteRequest = (state == WR_REQ);
    assign oReadRequest  = (state == RD_REQ);
    assign oDone         = (state == FINISH) || (state == ABORT);
    assign oError        = (state == ABORT);
    assign oState        = state;

endmodule

// File: tb/tb_sram_request_master.sv
// Bench for sram_request_master against a small cycle model of the 8-bit SRAM
// controller, with host-side writer/reader processes and expected-value queues.
module tb_sram_request_master;
    import sram_client_pkg::*;

    localparam int DW = 8;
    localparam int TO = 64;

    logic          iClk = 1'b0;
    logic          iReset = 1'b1;
    logic          iCmdValid, iCmdWrite;
    logic [3:0]    iCmdCount;
    logic [DW-1:0] iWrData;
    logic          iWrValid, iRdReady;
    logic [DW-1:0] iData;
    logic          iReadGranted, iWriteGranted, iReadDataValid, iDataWritten;
    logic          oCmdReady, oWrReady, oRdValid, oDone, oError, oBusy;
    logic          oReadRequest, oWriteRequest;
    logic [DW-1:0] oRdData, oData;
    state_t        oState;

    always #5 iClk = ~iClk;

    sram_request_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .iClk(iClk), .iReset(iReset),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite), .iCmdCount(iCmdCount),
        .iWrData(iWrData), .iWrValid(iWrValid), .oWrReady(oWrReady),
        .oRdData(oRdData), .oRdValid(oRdValid), .iRdReady(iRdReady),
        .oDone(oDone), .oError(oError), .oBusy(oBusy),
        .oReadRequest(oReadRequest), .oWriteRequest(oWriteRequest),
        .oData(oData), .iData(iData),
        .iReadGranted(iReadGranted), .iWriteGranted(iWriteGranted),
        .iReadDataValid(iReadDataValid), .iDataWritten(iDataWritten),
        .oState(oState)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] host_wr_q[$];
    logic [DW-1:0] wr_exp_q[$];
    logic [DW-1:0] rd_src_q[$];
    logic [DW-1:0] rd_exp_q[$];

    int wr_n = 0;
    int rd_n = 0;
    int withhold_idx = -1;
    int rd_hold_cfg = 0;
    int rd_hold_left = 0;
    bit wr_toggle = 0;
    bit stray = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Controller model: grant after 0..2 cycles, then completion level or read data.
    initial begin
        int phase = 0;
        int dly = 0;
        int w_cnt = 0;
        iWriteGranted = 0; iReadGranted = 0; iReadDataValid = 0; iDataWritten = 0; iData = '0;
        forever begin
            tick();
            iWriteGranted = 0; iReadGranted = 0; iReadDataValid = 0;
            if (oReadRequest && oWriteRequest) check("req_exclusive", 1, 0);
            if (stray) begin
                iReadGranted = 1; iWriteGranted = 1; iReadDataValid = 1; iData = 8'hEE;
                stray = 0;
            end else if (!oBusy) begin
                phase = 0;
                iDataWritten = 0;
            end else begin
                case (phase)
                    0: begin
                        if (oWriteRequest) begin
                            dly = $urandom_range(0, 2);
                            phase = 1;
                        end else if (oReadRequest) begin
                            if (rd_n == withhold_idx) begin
                                w_cnt = 1;
                                phase = 6;
                            end else begin
                                dly = $urandom_range(0, 2);
                                phase = 4;
                            end
                            rd_n++;
                        end
                    end
                    1: begin
                        if (!oWriteRequest) phase = 0;
                        else if (dly > 0) dly--;
                        else begin
                            iWriteGranted = 1;
                            wr_n++;
                            if (wr_exp_q.size() == 0) check("wr_unexpected", 1, 0);
                            else check("wr_data", oData, wr_exp_q.pop_front());
                            phase = 2;
                        end
                    end
                    2: begin
                        iDataWritten = 1;
                        dly = $urandom_range(1, 3);
                        phase = 3;
                    end
                    3: begin
                        // Level lingers past completion, as the real controller does.
                        if (dly > 0) dly--;
                        else begin
                            iDataWritten = 0;
                            phase = 0;
                        end
                    end
                    4: begin
                        if (!oReadRequest) phase = 0;
                        else if (dly > 0) dly--;
                        else begin
                            iReadGranted = 1;
                            phase = 5;
                        end
                    end
                    5: begin
                        iReadDataValid = 1;
                        iData = (rd_src_q.size() > 0) ? rd_src_q.pop_front() : DW'($urandom);
                        rd_exp_q.push_back(iData);
                        phase = 0;
                    end
                    6: begin
                        if (oReadRequest) w_cnt++;
                        else begin
                            check("timeout_len", w_cnt, TO);
                            phase = 0;
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    // Host write-data source.
    initial begin
        iWrValid = 0; iWrData = '0;
        forever begin
            tick();
            cyc++;
            iWrValid = 0;
            if (oWrReady && host_wr_q.size() > 0 && (!wr_toggle || (cyc % 2 == 0))) begin
                iWrValid = 1;
                iWrData = host_wr_q.pop_front();
            end
        end
    end

    // Host read-data sink with an optional hold-off before consuming.
    initial begin
        iRdReady = 0;
        forever begin
            tick();
            iRdReady = 0;
            if (oRdValid) begin
                if (rd_exp_q.size() == 0) check("rd_unexpected", 1, 0);
                else if (rd_hold_left > 0) begin
                    check("rd_hold_data", oRdData, rd_exp_q[0]);
                    check("rd_hold_noreq", oReadRequest, 0);
                    rd_hold_left--;
                end else begin
                    check("rd_data", oRdData, rd_exp_q.pop_front());
                    iRdReady = 1;
                    rd_hold_left = rd_hold_cfg;
                end
            end
        end
    end

    task automatic push_wr(input logic [DW-1:0] b);
        host_wr_q.push_back(b);
        wr_exp_q.push_back(b);
    endtask

    task automatic issue(input bit wr, input int cnt);
        int t = 0;
        while (!oCmdReady && t < 200) begin
            tick();
            t++;
        end
        if (!oCmdReady) check("cmd_ready_timeout", 0, 1);
        iCmdValid = 1;
        iCmdWrite = wr;
        iCmdCount = 4'(cnt);
        tick();
        iCmdValid = 0;
    endtask

    task automatic wait_done(input string tag, input bit exp_err);
        int t = 0;
        bit seen = 0;
        while (!seen && t < 2000) begin
            tick();
            t++;
            if (oDone) seen = 1;
        end
        check({tag, "_done"}, 32'(seen), 1);
        if (seen) check({tag, "_error"}, oError, 32'(exp_err));
        tick();
        check({tag, "_idle"}, oCmdReady, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, oCmdReady, 1);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_done"}, oDone, 0);
        check({tag, "_error"}, oError, 0);
        check({tag, "_wr_ready"}, oWrReady, 0);
        check({tag, "_rd_valid"}, oRdValid, 0);
        check({tag, "_rd_req"}, oReadRequest, 0);
        check({tag, "_wr_req"}, oWriteRequest, 0);
        check({tag, "_data"}, oData, 0);
        check({tag, "_rd_data"}, oRdData, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        iCmdValid = 0; iCmdWrite = 0; iCmdCount = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        iReset = 0;
        tick();

        // Three-byte write burst.
        wr_n = 0;
        push_wr(8'hA5); push_wr(8'h5A); push_wr(8'hFF);
        issue(1, 2);
        wait_done("wr3", 0);
        check("wr3_count", wr_n, 3);
        check("wr3_drained", wr_exp_q.size(), 0);

        // Single read, host holds off for 10 cycles.
        rd_hold_cfg = 10; rd_hold_left = 10;
        rd_src_q.push_back(8'h3C);
        issue(0, 0);
        wait_done("rd_hold", 0);
        check("rd_hold_drained", rd_exp_q.size(), 0);
        rd_hold_cfg = 0; rd_hold_left = 0;

        // Sixteen-byte write with a stalling host.
        wr_n = 0; wr_toggle = 1;
        for (int i = 0; i < 16; i++) push_wr(DW'($urandom));
        issue(1, 15);
        wait_done("wr16", 0);
        check("wr16_count", wr_n, 16);
        check("wr16_drained", wr_exp_q.size(), 0);
        wr_toggle = 0;

        // Grant withheld on the second read of four.
        rd_n = 0; withhold_idx = 1;
        for (int i = 0; i < 4; i++) rd_src_q.push_back(DW'($urandom));
        issue(0, 3);
        wait_done("abort", 1);
        check("abort_rd_req", oReadRequest, 0);
        check("abort_rd_valid", oRdValid, 0);
        check("abort_one_read", rd_exp_q.size(), 0);
        withhold_idx = -1;
        rd_src_q.delete();

        // Reset while waiting on write completion, then a clean read.
        push_wr(8'h11); push_wr(8'h22); push_wr(8'h33);
        issue(1, 2);
        t = 0;
        while (oState != WR_WAIT && t < 200) begin
            tick();
            t++;
        end
        check("rst_reach_wr_wait", 32'(oState == WR_WAIT), 1);
        iReset = 1;
        tick();
        check_idle_outputs("rst_mid");
        iReset = 0;
        host_wr_q.delete();
        wr_exp_q.delete();
        rd_src_q.push_back(8'h81); rd_src_q.push_back(8'h7E);
        issue(0, 1);
        wait_done("post_rst_rd", 0);
        check("post_rst_drained", rd_exp_q.size(), 0);

        // Stray controller pulses while idle.
        tick();
        stray = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stray_no_done", oDone, 0);
            check("stray_no_busy", oBusy, 0);
        end

        // A few random bursts.
        for (int k = 0; k < 4; k++) begin
            int cnt;
            bit wr;
            cnt = $urandom_range(0, 7);
            wr = 1'($urandom_range(0, 1));
            wr_n = 0;
            if (wr) for (int i = 0; i <= cnt; i++) push_wr(DW'($urandom));
            issue(wr, cnt);
            wait_done("rand", 0);
            if (wr) check("rand_wr_count", wr_n, cnt + 1);
            check("rand_drained", wr_exp_q.size() + rd_exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_request_master.md
SRAM_REQUEST_MASTER -- requirements
Module: sram_request_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width on all data ports.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum wait for a grant or a completion.
REQ-003 SHALL have ports, clock and reset first:
- iClk  in  1  single clock; all logic on its rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCmdValid  in  1  host command offered.
- oCmdReady  out  1  high only in IDLE.
- iCmdWrite  in  1  1 = write burst, 0 = read burst.
- iCmdCount  in  4  burst length minus one (1..16 transfers).
- iWrData  in  DATA_WIDTH  write byte from host.
- iWrValid  in  1  write byte valid.
- oWrReady  out  1  write byte accepted this cycle.
- oRdData  out  DATA_WIDTH  read byte to host.
- oRdValid  out  1  read byte held valid.
- iRdReady  in  1  host consumes read byte.
- oDone  out  1  one-cycle pulse at burst end.
- oError  out  1  valid with oDone; 1 = timeout abort.
- oBusy  out  1  high whenever the state is not IDLE.
- oReadRequest / oWriteRequest  out  1 each  requests to the SRAM controller.
- oData  out  DATA_WIDTH  write byte to the controller.
- iData  in  DATA_WIDTH  read byte from the controller.
- iReadGranted / iWriteGranted  in  1 each  one-cycle grant pulses.
- iReadDataValid  in  1  one-cycle read-data pulse.
- iDataWritten  in  1  level; high from the write strobe until the controller returns to idle.

Function
REQ-004 SHALL use states IDLE, WR_FETCH, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_HOLD, FINISH, ABORT.
REQ-005 IDLE: when iCmdValid && oCmdReady, latch iCmdWrite and remaining = iCmdCount; go to WR_FETCH if write, else RD_REQ.
REQ-006 WR_FETCH: assert oWrReady; on iWrValid, register iWrData into oData and go to WR_REQ.
REQ-007 oData SHALL stay stable from WR_REQ entry until WR_WAIT exit.
REQ-008 A host stall (iWrValid low) SHALL wait indefinitely and SHALL NOT be timed.
REQ-009 WR_REQ: hold oWriteRequest high; on the cycle iWriteGranted is seen, drop oWriteRequest (registered, so it falls next edge) and go to WR_WAIT.
REQ-010 WR_WAIT: on iDataWritten high, the transfer is complete. If remaining==0 go to FINISH; else decrement remaining and go to WR_FETCH.
REQ-011 iDataWritten SHALL be evaluated only after the grant, so a stale level from the previous write is never taken as completion.
REQ-012 RD_REQ: hold oReadRequest until iReadGranted, then drop it and go to RD_WAIT.
REQ-013 RD_WAIT: on iReadDataValid, capture iData into oRdData, set oRdValid, and go to RD_HOLD.
REQ-014 RD_HOLD: keep oRdData/oRdValid stable until iRdReady. Then clear oRdValid; if remaining==0 go to FINISH, else decrement and go to RD_REQ.
REQ-015 No new read request SHALL issue while oRdValid is high (no read buffering).
REQ-016 At most one of oReadRequest and oWriteRequest SHALL be high in any cycle.
REQ-017 A wait counter SHALL clear on entry to WR_REQ, WR_WAIT, RD_REQ and RD_WAIT, and increment each cycle spent there.
REQ-018 When the wait counter reaches TIMEOUT_CYCLES-1 while waiting, go to ABORT: drop both requests, clear oRdValid, discard remaining.
REQ-019 FINISH: pulse oDone with oError=0, then go to IDLE. ABORT: pulse oDone with oError=1, then go to IDLE.
REQ-020 A grant or data pulse arriving in IDLE, FINISH or ABORT SHALL be ignored.
REQ-021 iCmdCount=15 SHALL perform exactly 16 transfers; remaining SHALL NOT wrap below 0.

Reset
REQ-022 iReset high at any edge, including mid-burst, SHALL force state IDLE and clear the wait counter and remaining.
REQ-023 On reset, all outputs SHALL be 0 except oCmdReady, which SHALL be 1 in the cycle after reset; oData and oRdData SHALL clear to 0.

Structure
REQ-024 The state enum and the default TIMEOUT_CYCLES SHALL live in shared package sram_client_pkg.
REQ-025 The wait counter SHALL be sub-module sram_watchdog, with ports clear, enable, expired and parameter TIMEOUT_CYCLES.

Verification
REQ-026 The bench SHALL cover these scenarios, each against a cycle model of the 8-bit SRAM controller:
- Write, count=2, bytes 0xA5,0x5A,0xFF -> three write requests, oData matches each byte; oDone=1, oError=0.
- Read, count=0, controller returns 0x3C; iRdReady held low 10 cycles -> oRdData=0x3C held stable; no new request; oDone after iRdReady.
- Write, count=15 with iWrValid toggling every other cycle -> 16 writes in order; no timeout.
- Grant withheld 64 cycles on the second read of count=3 -> oDone=1, oError=1; oReadRequest low next cycle.
- Reset asserted in WR_WAIT -> next cycle all outputs 0, oCmdReady=1; a new read command completes normally.
- Stray iReadGranted pulse in IDLE -> no state change, no oDone.
